// File: rtl/mdu_if.sv
// mdu_if - operand / control / result bundle between execute-stage control
// and the multiply/divide unit.
//   A, B    : operand buses (rs, rt), shared with the ALU
//   MDUOp   : operation select (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//             5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 NOP)
//   Start   : issue strobe for MDUOp 1-6
//   Busy    : multiply/divide in flight
//   HI, LO  : architectural HI/LO registers
//   Out     : combinational MFHI/MFLO read data for the writeback mux
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output A, B, MDUOp, Start,
    input  Busy, HI, LO, Out
  );

  modport slave (
    input  A, B, MDUOp, Start,
    output Busy, HI, LO, Out
  );
endinterface

// File: rtl/mdu.sv
// mdu - multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed at the issue edge into pending registers {PH,PL};
// a down-counter then models the multi-cycle latency, and HI/LO are written
// at the edge where the counter reaches zero.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : mdu_if.slave (A, B, MDUOp, Start in; Busy, HI, LO, Out out)
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   ph_q, ph_d, pl_q, pl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic        busy;
  logic        issue;
  logic [63:0] mul_s, mul_u;
  logic [31:0] a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;

  assign busy = (cnt_q != '0);

  // Arithmetic datapath, evaluated on the live operands; only consumed
  // at the issue edge, so later operand changes have no effect.
  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed product.
    mul_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    mul_u = {32'd0, bus.A} * {32'd0, bus.B};

    b_zero   = (bus.B == 32'd0);
    // A zero divisor is replaced by 1 so the divider never sees /0;
    // the result is suppressed at completion anyway.
    b_safe_u = b_zero ? 32'd1 : bus.B;

    // Signed divide via magnitudes. 0x80000000 / -1 falls out naturally:
    // |A| = 0x80000000, quotient magnitude 0x80000000, signs agree -> LO = 0x80000000, HI = 0.
    a_mag    = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    b_mag    = bus.B[31] ? (32'd0 - bus.B) : bus.B;
    b_safe_s = b_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    q_s      = (bus.A[31] ^ bus.B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s      = bus.A[31] ? (32'd0 - r_mag) : r_mag;

    q_u      = bus.A / b_safe_u;
    r_u      = bus.A % b_safe_u;
  end

  // Next-state logic
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    ph_d  = ph_q;
    pl_d  = pl_q;
    dz_d  = dz_q;
    cnt_d = busy ? (cnt_q - CW'(1)) : cnt_q;
    issue = bus.Start && !busy;

    // Completion: counter going 1 -> 0 commits the pending result.
    if (cnt_q == CW'(1) && !dz_q) begin
      hi_d = ph_q;
      lo_d = pl_q;
    end

    if (issue) begin
      case (bus.MDUOp)
        OP_MULT: begin
          {ph_d, pl_d} = mul_s;
          dz_d         = 1'b0;
          cnt_d        = MULT_CNT;
        end
        OP_MULTU: begin
          {ph_d, pl_d} = mul_u;
          dz_d         = 1'b0;
          cnt_d        = MULT_CNT;
        end
        OP_DIV: begin
          ph_d  = r_s;
          pl_d  = q_s;
          dz_d  = b_zero;
          cnt_d = DIV_CNT;
        end
        OP_DIVU: begin
          ph_d  = r_u;
          pl_d  = q_u;
          dz_d  = b_zero;
          cnt_d = DIV_CNT;
        end
        OP_MTHI: hi_d = bus.A;
        OP_MTLO: lo_d = bus.A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      ph_q  <= '0;
      pl_q  <= '0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      ph_q  <= ph_d;
      pl_q  <= pl_d;
      dz_q  <= dz_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.Busy = busy;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Writeback read port: architectural registers only, never the pending pair.
  always_comb begin
    bus.Out = 32'd0;
    if (bus.MDUOp == OP_MFHI)      bus.Out = hi_q;
    else if (bus.MDUOp == OP_MFLO) bus.Out = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu - self-checking bench for mdu: directed cases for the documented
// corner values plus randomized operation streams, checked against a
// reference model computed with plain integer arithmetic.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic rst_n;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference result of an arithmetic op; returns the pair HI/LO should hold
  // after completion (unchanged for divide by zero).
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl);
    int               sa, sb, q, r;
    longint           ps;
    longint unsigned  pu, ua, ub;
    sa = a; sb = b;
    nh = exp_hi; nl = exp_lo;
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb); nh = ps[63:32]; nl = ps[31:0]; end
      4'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; pu = ua * ub; nh = pu[63:32]; nl = pu[31:0]; end
      4'd3: begin
        if (b == 32'd0) ;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin nl = 32'h8000_0000; nh = 32'd0; end
        else begin q = sa / sb; r = sa % sb; nl = q; nh = r; end
      end
      4'd4: if (b != 32'd0) begin nl = a / b; nh = a % b; end
      default: ;
    endcase
  endtask

  // Read port check; called at a negedge, returns in the same half cycle.
  task automatic rd_chk(input string tag);
    bus.MDUOp = 4'd7; #1 chk({tag, "_mfhi"}, bus.Out, exp_hi);
    bus.MDUOp = 4'd8; #1 chk({tag, "_mflo"}, bus.Out, exp_lo);
    bus.MDUOp = 4'd0; #1 chk({tag, "_nop_out"}, bus.Out, 32'd0);
  endtask

  // Issue one operation; called at a negedge and returns at the negedge where
  // the result is architecturally visible. inject=1 fires MTLO and MULT
  // strobes during Busy, which must be ignored.
  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
    logic [31:0] nh, nl;
    int cnt, n;
    model(op, a, b, nh, nl);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 4'd0; bus.A = $urandom; bus.B = $urandom;
    if (op >= 4'd1 && op <= 4'd4) begin
      n = (op <= 4'd2) ? MC : DC;
      cnt = 0;
      while (bus.Busy && cnt < 200) begin
        cnt++;
        if (cnt == 1) begin
          chk("hold_hi", bus.HI, exp_hi);
          chk("hold_lo", bus.LO, exp_lo);
        end
        if (inject && cnt == 1) begin bus.Start = 1'b1; bus.MDUOp = 4'd6; bus.A = 32'hDEAD_BEEF; end
        if (inject && cnt == 2) begin bus.MDUOp = 4'd1; bus.A = $urandom; bus.B = $urandom; end
        if (inject && cnt == 3) begin bus.Start = 1'b0; bus.MDUOp = 4'd0; end
        if (!inject) begin bus.A = $urandom; bus.B = $urandom; end
        @(negedge clk);
      end
      chk("busy_len", cnt, n);
      exp_hi = nh; exp_lo = nl;
    end else begin
      if (op == 4'd5) exp_hi = a;
      if (op == 4'd6) exp_lo = a;
      chk("no_busy", {31'd0, bus.Busy}, 32'd0);
    end
    chk("hi", bus.HI, exp_hi);
    chk("lo", bus.LO, exp_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0; bus.MDUOp = '0; bus.Start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    rd_chk("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner values
    issue_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF); chk("mult_lo", bus.LO, 32'hFFFF_FFFE);
    issue_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    chk("multu_hi", bus.HI, 32'h0000_0001); chk("multu_lo", bus.LO, 32'hFFFF_FFFE);
    issue_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF); chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    issue_op(4'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("divu_hi", bus.HI, 32'h0000_0001); chk("divu_lo", bus.LO, 32'h7FFF_FFFC);
    issue_op(4'd5, 32'h1111_1111, 32'd0, 1'b0);
    issue_op(4'd6, 32'h2222_2222, 32'd0, 1'b0);
    issue_op(4'd3, 32'h1234_5678, 32'd0, 1'b0);
    chk("dz_hi", bus.HI, 32'h1111_1111); chk("dz_lo", bus.LO, 32'h2222_2222);
    issue_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_hi", bus.HI, 32'h0000_0000); chk("ovf_lo", bus.LO, 32'h8000_0000);
    issue_op(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    rd_chk("dir");

    // Randomized back-to-back stream, including NOP codes with Start
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) op = 4'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF);
        default: ;
      endcase
      issue_op(op, a, b, ($urandom_range(0, 3) == 0));
      if (i % 8 == 0) rd_chk("rnd");
    end

    // Reset during the 3rd Busy cycle of a multiply
    bus.MDUOp = 4'd1; bus.A = 32'h0001_2345; bus.B = 32'h0006_789A; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
    rst_n = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    #1;
    chk("arst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("arst_hi", bus.HI, 32'd0);
    chk("arst_lo", bus.LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("post_rst_hi", bus.HI, 32'd0);
    chk("post_rst_lo", bus.LO, 32'd0);
    rd_chk("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the ALU.
- Consumes the same A/B operand buses the ALU consumes. Holds the architectural HI/LO registers.
- Its read port feeds the writeback mux in parallel with the ALU Result.
- Exposes Busy so the control/hazard logic can stall later MDU instructions.

Parameters:
- MULT_CYCLES, 5, Busy duration for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, Busy duration for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- B  input  32  operand rt (divisor / multiplier).
- MDUOp  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 behave as NOP.
- Start  input  1  issue strobe; qualifies MDUOp 1-6 for one cycle.
- Busy  output  1  high while a multiply/divide is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- Out  output  32  combinational read data: HI if MDUOp=7, LO if MDUOp=8, else 0.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, cycle counter=0, pending-result registers=0.
  - Applies mid-operation too: the in-flight result is discarded.
  - Out follows HI/LO, so it is 0 under reset.
- Issue condition: Start=1 and Busy=0 at a rising edge. If Start=1 while Busy=1, the strobe is ignored entirely (no state change).
- MULT/MULTU issue:
  - Latch the 64-bit product of A and B into the pending {PH,PL}.
  - MULT is signed×signed; MULTU is unsigned×unsigned.
  - Load counter with MULT_CYCLES.
- DIV/DIVU issue:
  - Latch PL=quotient, PH=remainder.
  - DIV is signed: quotient truncated toward zero; remainder takes the sign of the dividend (A).
  - DIVU is unsigned.
  - Load counter with DIV_CYCLES.
- Divide special cases:
  - B=0: counter still runs the full DIV_CYCLES; on completion HI/LO keep their prior values (no write).
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy = (counter != 0).
  - Busy rises in the cycle after the issuing edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - The counter decrements once per edge while nonzero.
- Completion: at the edge where the counter goes 1→0, HI<=PH and LO<=PL (except divide-by-zero). New values are visible in the first cycle with Busy=0.
- Back-to-back: a new Start may be accepted at the same edge where Busy was sampled 0, i.e. the cycle right after completion.
- MTHI/MTLO: on issue (Busy=0), HI<=A or LO<=A at that edge. Busy is not asserted. Only the named register changes.
- MFHI/MFLO are pure combinational reads of architectural HI/LO; pending results are never visible. Start is don't-care for MDUOp 7/8.
- Operands A/B are sampled only at the issue edge; later changes on A/B while Busy have no effect.
- No other outputs change during Busy. HI/LO stay at their old values until completion.

Test Plan:
- Reset then MFHI/MFLO -> Out=0 in both cases, Busy=0.
- MULT A=0xFFFFFFFF (-1), B=0x00000002, Start pulse:
  - Busy=1 for exactly 5 cycles.
  - Next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat as MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> Busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIV by zero after MTHI 0x11111111 / MTLO 0x22222222 -> Busy 10 cycles, HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT issued, then Start with MTLO A=0xDEADBEEF and a new MULT during Busy -> both ignored; only the first product lands in HI/LO.
  - A/B changed while Busy -> result unaffected.
- Assert reset (0) on the 3rd Busy cycle of a MULT -> Busy, HI, LO go 0 immediately (before the next edge) and stay 0 after reset releases.
